// File: rtl/color_pkg.sv
// Shared widths and configuration register map for the color palette bank.
package color_pkg;
  localparam int RGB_W = 24;
  localparam int NIB_W = 4;

  localparam logic [3:0] ADDR_R_HI     = 4'd3;
  localparam logic [3:0] ADDR_R_LO     = 4'd4;
  localparam logic [3:0] ADDR_G_HI     = 4'd5;
  localparam logic [3:0] ADDR_G_LO     = 4'd6;
  localparam logic [3:0] ADDR_B_HI     = 4'd7;
  localparam logic [3:0] ADDR_B_LO     = 4'd8;
  localparam logic [3:0] ADDR_COMMIT   = 4'd9;
  localparam logic [3:0] ADDR_EDIT_IDX = 4'd10;
endpackage

// File: rtl/rise_detect.sv
// One-register rising-edge detector; the register clears on reset so a level
// held through reset release reads as a fresh edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= d;
  end

  assign rise = d & ~r_q;
endmodule

// File: rtl/color_palette_bank.sv
// Per-channel palette bank: nibble-staged color writes committed into a
// flop palette, with a per-channel display index driving rgb_out.
module color_palette_bank
  import color_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PAL_DEPTH = 4,
  parameter int IDX_W     = $clog2(PAL_DEPTH),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_W-1:0]           channel,
  input  logic [3:0]                address,
  input  logic [NIB_W-1:0]          data,
  input  logic                      valid,
  input  logic                      color_next,
  output logic                      ack,
  output logic [NUM_CH*RGB_W-1:0]   rgb_out,
  output logic [NUM_CH*IDX_W-1:0]   disp_idx
);
  logic w_v_rise, w_cn_rise;
  logic w_wr, w_adv;
  logic r_ack;

  rise_detect u_rd_valid (.clk(clk), .rst(rst), .d(valid),      .rise(w_v_rise));
  rise_detect u_rd_next  (.clk(clk), .rst(rst), .d(color_next), .rise(w_cn_rise));

  // an edge landing on a reset cycle is dropped
  assign w_wr  = w_v_rise  & ~rst;
  assign w_adv = w_cn_rise & ~rst;

  always_ff @(posedge clk) begin
    if (rst) r_ack <= 1'b0;
    else     r_ack <= w_wr;
  end
  assign ack = r_ack;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic                 w_hit;
    logic [RGB_W-1:0]     r_stage;
    logic [IDX_W-1:0]     r_edit;
    logic [IDX_W-1:0]     r_disp;
    logic [RGB_W-1:0]     r_pal [PAL_DEPTH];
    logic [RGB_W-1:0]     w_rgb;

    // out-of-range channel codes match no lane and are silently ignored
    assign w_hit = (32'(channel) == k);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_stage <= '0;
        r_edit  <= '0;
        r_disp  <= '0;
        for (int e = 0; e < PAL_DEPTH; e++) r_pal[e] <= '0;
      end else begin
        if (w_wr && w_hit) begin
          case (address)
            ADDR_R_HI:     r_stage[23 -: NIB_W] <= data;
            ADDR_R_LO:     r_stage[19 -: NIB_W] <= data;
            ADDR_G_HI:     r_stage[15 -: NIB_W] <= data;
            ADDR_G_LO:     r_stage[11 -: NIB_W] <= data;
            ADDR_B_HI:     r_stage[7  -: NIB_W] <= data;
            ADDR_B_LO:     r_stage[3  -: NIB_W] <= data;
            ADDR_COMMIT:
              for (int e = 0; e < PAL_DEPTH; e++)
                if (r_edit == IDX_W'(e)) r_pal[e] <= r_stage;
            ADDR_EDIT_IDX: r_edit <= IDX_W'(32'(data) % PAL_DEPTH);
            default: ;
          endcase
        end
        if (w_adv && w_hit)
          r_disp <= (r_disp == IDX_W'(PAL_DEPTH - 1)) ? '0 : r_disp + IDX_W'(1);
      end
    end

    always_comb begin
      w_rgb = '0;
      for (int e = 0; e < PAL_DEPTH; e++)
        if (r_disp == IDX_W'(e)) w_rgb = r_pal[e];
    end

    assign rgb_out[RGB_W*k +: RGB_W]  = w_rgb;
    assign disp_idx[IDX_W*k +: IDX_W] = r_disp;
  end
endmodule

// File: tb/tb_color_palette_bank.sv
// Randomized + directed bench for color_palette_bank with a queue scoreboard.
module tb_color_palette_bank;
  localparam int NCH = 4;
  localparam int PD  = 4;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        channel;
  logic [3:0]        address;
  logic [3:0]        data;
  logic              valid;
  logic              color_next;
  logic              ack;
  logic [NCH*24-1:0] rgb_out;
  logic [NCH*IW-1:0] disp_idx;

  color_palette_bank #(.NUM_CH(NCH), .PAL_DEPTH(PD), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .channel(channel), .address(address), .data(data),
    .valid(valid), .color_next(color_next), .ack(ack),
    .rgb_out(rgb_out), .disp_idx(disp_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              ack;
    logic [NCH*24-1:0] rgb;
    logic [NCH*IW-1:0] disp;
  } exp_t;

  exp_t sb[$];
  int   ntest = 0;
  int   nfail = 0;

  // reference model: palette as plain integers, staging as six nibbles R hi..B lo
  int       m_pal [NCH][PD];
  int       m_nib [NCH][6];
  int       m_edit[NCH];
  int       m_disp[NCH];
  bit       m_pv, m_pc;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      for (int e = 0; e < PD; e++) m_pal[c][e] = 0;
      for (int n = 0; n < 6; n++)  m_nib[c][n] = 0;
      m_edit[c] = 0;
      m_disp[c] = 0;
    end
    m_pv = 0;
    m_pc = 0;
  endtask

  task automatic cyc(input bit v, input bit cn, input int ch, input int a,
                     input int d, input bit r);
    exp_t e;
    bit   vr, cr;
    int   col;
    @(negedge clk);
    valid = v; color_next = cn; channel = 2'(ch);
    address = 4'(a); data = 4'(d); rst = r;
    e.ack = 1'b0;
    if (r) begin
      model_clear();
    end else begin
      vr = v && !m_pv;
      cr = cn && !m_pc;
      m_pv = v;
      m_pc = cn;
      e.ack = vr;
      if (vr && ch < NCH) begin
        if (a >= 3 && a <= 8) m_nib[ch][a-3] = d;
        else if (a == 9) begin
          col = 0;
          for (int n = 0; n < 6; n++) col = col * 16 + m_nib[ch][n];
          m_pal[ch][m_edit[ch]] = col;
        end else if (a == 10) m_edit[ch] = d % PD;
      end
      if (cr && ch < NCH) m_disp[ch] = (m_disp[ch] + 1) % PD;
    end
    for (int k = 0; k < NCH; k++) begin
      e.rgb[24*k +: 24] = 24'(m_pal[k][m_disp[k]]);
      e.disp[IW*k +: IW] = IW'(m_disp[k]);
    end
    sb.push_back(e);
  endtask

  task automatic wr(input int ch, input int a, input int d);
    cyc(1, 0, ch, a, d, 0);
    cyc(0, 0, ch, a, d, 0);
  endtask

  task automatic adv(input int ch);
    cyc(0, 1, ch, 0, 0, 0);
    cyc(0, 0, ch, 0, 0, 0);
  endtask

  // monitor: one expected record per clock edge, checked just after the edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ntest++;
      if (ack !== e.ack || rgb_out !== e.rgb || disp_idx !== e.disp) begin
        nfail++;
        $display("FAIL state t=%0t: got ack=%0b rgb=%h disp=%h, want ack=%0b rgb=%h disp=%h",
                 $time, ack, rgb_out, disp_idx, e.ack, e.rgb, e.disp);
      end
    end
  end

  initial begin
    valid = 0; color_next = 0; channel = 0; address = 0; data = 0; rst = 1;
    model_clear();

    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 0);

    // channel 0: 0xAAAAAA into entry 0
    for (int a = 3; a <= 8; a++) wr(0, a, 4'hA);
    wr(0, 9, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // channel 2: edit index 1, 0x123456, then advance through a full wrap
    wr(2, 10, 1);
    for (int a = 3; a <= 8; a++) wr(2, a, a - 2);
    wr(2, 9, 0);
    adv(2);
    repeat (4) adv(2);

    // valid held 20 cycles while address/data wander: one op only
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, (i < 10) ? 4 : 9, i, 0);
    cyc(0, 0, 1, 0, 0, 0);
    wr(1, 9, 0);

    // channel 3: commit and advance on the same edge
    wr(3, 10, 1);
    for (int a = 3; a <= 8; a++) wr(3, a, 15 - a);
    cyc(1, 1, 3, 9, 0, 0);
    cyc(0, 0, 3, 0, 0, 0);

    // reserved addresses ack with no state change
    wr(0, 0, 5); wr(0, 11, 3); wr(0, 15, 1);

    // partial staging, reset mid-sequence, then commit without restaging
    wr(1, 3, 4'hF); wr(1, 4, 4'hE); wr(1, 10, 2);
    cyc(1, 1, 1, 5, 4'hD, 1);
    cyc(0, 0, 1, 0, 0, 0);
    wr(1, 9, 0);
    adv(1);

    // inputs held high through reset release count as fresh edges
    cyc(1, 1, 2, 3, 7, 1);
    cyc(1, 1, 2, 3, 7, 0);
    cyc(0, 0, 2, 0, 0, 0);

    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          $urandom_range(0, NCH - 1),
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : $urandom_range(3, 10),
          $urandom_range(0, 15), ($urandom_range(0, 99) == 0));

    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    ntest++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d records left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
